// File: rtl/vend_output_ctrl_if.sv
// Purpose: request/drive/status bundle between vending_machine, the output
//          controller and the chute hardware.
// Ports:   master drives dispense/change/drop_sensor and observes the rest;
//          slave (the controller) receives requests and drives actuators/status.
interface vend_output_ctrl_if #(
    parameter int STOCK_W = 8
);
    logic               dispense;    // 1-cycle vend request
    logic               change;      // 1-cycle change-coin request
    logic               drop_sensor; // item passing the chute sensor
    logic               motor_on;    // product motor drive
    logic               change_sol;  // change solenoid drive
    logic               vend_done;   // drop confirmed pulse
    logic               vend_fail;   // dispense discarded at zero stock pulse
    logic               req_drop;    // request lost to a full queue pulse
    logic [STOCK_W-1:0] stock;       // remaining items
    logic               sold_out;    // stock == 0
    logic               busy;        // controller not idle
    logic               fault;       // sticky jam indicator

    modport master (
        output dispense, change, drop_sensor,
        input  motor_on, change_sol, vend_done, vend_fail, req_drop,
               stock, sold_out, busy, fault
    );

    modport slave (
        input  dispense, change, drop_sensor,
        output motor_on, change_sol, vend_done, vend_fail, req_drop,
               stock, sold_out, busy, fault
    );
endinterface

// File: rtl/vend_output_ctrl.sv
// Purpose: drives product motor and change solenoid from queued vend/change
//          requests, confirms drops, tracks stock and latches jam faults.
// Latency: request at edge N is queued at N, serviced from edge N+1; outputs
//          registered except sold_out (combinational from stock).
// Backpressure: none upstream; requests queue in 2-bit saturating counters,
//          overflow is reported by a 1-cycle req_drop pulse.
// Ports:   clk, reset (async active-high), bus (slave side of vend_output_ctrl_if).
module vend_output_ctrl #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CHANGE_CYCLES  = 4,
    parameter int INIT_STOCK     = 10,
    parameter int STOCK_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    vend_output_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VEND      = 3'd1,
        WAIT_DROP = 3'd2,
        CHANGE    = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int CNT_MAX_A = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CHANGE_CYCLES) ? CNT_MAX_A : CHANGE_CYCLES;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [STOCK_W-1:0] stock_q, stock_nxt;
    logic [1:0]         pend_disp, pend_disp_nxt;
    logic [1:0]         pend_chg, pend_chg_nxt;
    logic               take_disp, take_chg;
    logic               done_nxt, fail_nxt, drop_nxt;
    logic               motor_q, sol_q, done_q, fail_q, drop_q, busy_q, fault_q;

    // Next-state and registered-output intent
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stock_nxt = stock_q;
        take_disp = 1'b0;
        take_chg  = 1'b0;
        done_nxt  = 1'b0;
        fail_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // Dispense wins over change so a purchase pays the item first.
                if (pend_disp != 2'd0) begin
                    take_disp = 1'b1;
                    if (stock_q != '0) begin
                        state_nxt = VEND;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        fail_nxt = 1'b1;
                    end
                end else if (pend_chg != 2'd0) begin
                    take_chg  = 1'b1;
                    state_nxt = CHANGE;
                    cnt_nxt   = CNT_W'(1);
                end
            end

            VEND: begin
                if (bus.drop_sensor) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    if (stock_q != '0) stock_nxt = stock_q - STOCK_W'(1);
                end else if (cnt == CNT_W'(MOTOR_CYCLES)) begin
                    state_nxt = WAIT_DROP;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            WAIT_DROP: begin
                if (bus.drop_sensor) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    if (stock_q != '0) stock_nxt = stock_q - STOCK_W'(1);
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_nxt = FAULT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            CHANGE: begin
                if (cnt == CNT_W'(CHANGE_CYCLES)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            FAULT: begin
                state_nxt = FAULT;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request queues: simultaneous increment and consume cancel out; a
    // request into a full queue (not drained this edge) is lost and reported.
    always_comb begin
        pend_disp_nxt = pend_disp;
        pend_chg_nxt  = pend_chg;
        drop_nxt      = 1'b0;

        if (bus.dispense && !take_disp) begin
            if (pend_disp == 2'd3) drop_nxt = 1'b1;
            else                   pend_disp_nxt = pend_disp + 2'd1;
        end else if (!bus.dispense && take_disp) begin
            pend_disp_nxt = pend_disp - 2'd1;
        end

        if (bus.change && !take_chg) begin
            if (pend_chg == 2'd3) drop_nxt = 1'b1;
            else                  pend_chg_nxt = pend_chg + 2'd1;
        end else if (!bus.change && take_chg) begin
            pend_chg_nxt = pend_chg - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stock_q   <= STOCK_W'(INIT_STOCK);
            pend_disp <= 2'd0;
            pend_chg  <= 2'd0;
            motor_q   <= 1'b0;
            sol_q     <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stock_q   <= stock_nxt;
            pend_disp <= pend_disp_nxt;
            pend_chg  <= pend_chg_nxt;
            // Actuators follow the state being entered so they switch on the
            // same edge as the transition.
            motor_q   <= (state_nxt == VEND);
            sol_q     <= (state_nxt == CHANGE);
            done_q    <= done_nxt;
            fail_q    <= fail_nxt;
            drop_q    <= drop_nxt;
            busy_q    <= (state_nxt != IDLE);
            fault_q   <= (state_nxt == FAULT);
        end
    end

    assign bus.motor_on   = motor_q;
    assign bus.change_sol = sol_q;
    assign bus.vend_done  = done_q;
    assign bus.vend_fail  = fail_q;
    assign bus.req_drop   = drop_q;
    assign bus.stock      = stock_q;
    assign bus.sold_out   = (stock_q == '0);
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_vend_output_ctrl.sv
// Purpose: directed self-checking bench for vend_output_ctrl (default
//          parameters plus a single-item stock instance).
module tb_vend_output_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    vend_output_ctrl_if #(.STOCK_W(8)) vif ();
    vend_output_ctrl_if #(.STOCK_W(8)) vif1 ();

    vend_output_ctrl #(
        .MOTOR_CYCLES(8), .TIMEOUT_CYCLES(32), .CHANGE_CYCLES(4),
        .INIT_STOCK(10), .STOCK_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    vend_output_ctrl #(
        .MOTOR_CYCLES(8), .TIMEOUT_CYCLES(32), .CHANGE_CYCLES(4),
        .INIT_STOCK(1), .STOCK_W(8)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (vif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait for a vend to start, run drop_at motor cycles, then drop.
    task automatic do_vend(input int drop_at, input string tag);
        int w;
        w = 0;
        while (!vif.motor_on && w < 10) begin
            tick();
            w++;
        end
        chk({tag, "_start"}, 32'(vif.motor_on), 32'd1);
        for (int k = 1; k < drop_at; k++) begin
            tick();
            chk({tag, "_motor"}, 32'(vif.motor_on), 32'd1);
        end
        vif.drop_sensor = 1'b1;
        tick();
        vif.drop_sensor = 1'b0;
        chk({tag, "_done"}, 32'(vif.vend_done), 32'd1);
        chk({tag, "_motoroff"}, 32'(vif.motor_on), 32'd0);
    endtask

    initial begin
        int mc;
        int wc;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        vif.dispense     = 1'b0;
        vif.change       = 1'b0;
        vif.drop_sensor  = 1'b0;
        vif1.dispense    = 1'b0;
        vif1.change      = 1'b0;
        vif1.drop_sensor = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_motor",   32'(vif.motor_on),   32'd0);
        chk("rst_sol",     32'(vif.change_sol), 32'd0);
        chk("rst_stock",   32'(vif.stock),      32'd10);
        chk("rst_soldout", 32'(vif.sold_out),   32'd0);
        chk("rst_busy",    32'(vif.busy),       32'd0);
        chk("rst_fault",   32'(vif.fault),      32'd0);
        chk("rst_stock1",  32'(vif1.stock),     32'd1);
        reset = 1'b0;
        tick();

        // 1: single dispense, drop in motor cycle 5
        vif.dispense = 1'b1;
        tick();
        vif.dispense = 1'b0;
        chk("t1_queued_motor", 32'(vif.motor_on), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t1_motor", 32'(vif.motor_on), 32'd1);
            if (k == 5) vif.drop_sensor = 1'b1;
        end
        tick();
        vif.drop_sensor = 1'b0;
        chk("t1_motoroff", 32'(vif.motor_on),  32'd0);
        chk("t1_done",     32'(vif.vend_done), 32'd1);
        chk("t1_stock",    32'(vif.stock),     32'd9);
        chk("t1_busy",     32'(vif.busy),      32'd0);
        tick();
        chk("t1_done_w", 32'(vif.vend_done), 32'd0);

        // 2: dispense + change together, drop at motor cycle 3
        do_reset();
        vif.dispense = 1'b1;
        vif.change   = 1'b1;
        tick();
        vif.dispense = 1'b0;
        vif.change   = 1'b0;
        do_vend(3, "t2");
        chk("t2_stock", 32'(vif.stock),      32'd9);
        chk("t2_sol0",  32'(vif.change_sol), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t2_sol", 32'(vif.change_sol), 32'd1);
        end
        tick();
        chk("t2_soloff", 32'(vif.change_sol), 32'd0);
        chk("t2_busy",   32'(vif.busy),       32'd0);
        mc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (vif.motor_on || vif.change_sol || vif.busy) mc++;
        end
        chk("t2_queues_empty", 32'(mc), 32'd0);

        // 3: four dispenses during a vend -> one req_drop, three more vends
        do_reset();
        vif.dispense = 1'b1;
        tick();
        vif.dispense = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            vif.dispense = 1'b1;
            tick();
            chk("t3_reqdrop", 32'(vif.req_drop), (i == 4) ? 32'd1 : 32'd0);
        end
        vif.dispense = 1'b0;
        chk("t3_motor_mid", 32'(vif.motor_on), 32'd1);
        vif.drop_sensor = 1'b1;
        tick();
        vif.drop_sensor = 1'b0;
        chk("t3_done1",    32'(vif.vend_done), 32'd1);
        chk("t3_reqdrop0", 32'(vif.req_drop),  32'd0);
        do_vend(2, "t3_v2");
        do_vend(2, "t3_v3");
        do_vend(2, "t3_v4");
        mc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (vif.motor_on) mc++;
        end
        chk("t3_no_extra_vend", 32'(mc),           32'd0);
        chk("t3_stock",         32'(vif.stock),    32'd6);
        chk("t3_soldout",       32'(vif.sold_out), 32'd0);

        // 4: single-item stock: first vend confirmed, second fails
        vif1.dispense = 1'b1;
        tick();
        vif1.dispense = 1'b0;
        tick();
        chk("t4_motor", 32'(vif1.motor_on), 32'd1);
        vif1.drop_sensor = 1'b1;
        tick();
        vif1.drop_sensor = 1'b0;
        chk("t4_done",    32'(vif1.vend_done), 32'd1);
        chk("t4_stock0",  32'(vif1.stock),     32'd0);
        chk("t4_soldout", 32'(vif1.sold_out),  32'd1);
        tick();
        vif1.dispense = 1'b1;
        tick();
        vif1.dispense = 1'b0;
        tick();
        chk("t4_fail",       32'(vif1.vend_fail), 32'd1);
        chk("t4_motor_off",  32'(vif1.motor_on),  32'd0);
        chk("t4_stock_hold", 32'(vif1.stock),     32'd0);
        tick();
        chk("t4_fail_w", 32'(vif1.vend_fail), 32'd0);
        chk("t4_busy",   32'(vif1.busy),      32'd0);

        // 5: no drop -> 8 motor cycles, 32 wait cycles, sticky fault
        do_reset();
        vif.dispense = 1'b1;
        tick();
        vif.dispense = 1'b0;
        tick();
        mc = 0;
        while (vif.motor_on && mc < 20) begin
            mc++;
            tick();
        end
        chk("t5_motor_cycles", 32'(mc), 32'd8);
        wc = 0;
        while (vif.busy && !vif.fault && wc < 100) begin
            wc++;
            tick();
        end
        chk("t5_wait_cycles", 32'(wc),        32'd32);
        chk("t5_fault",       32'(vif.fault), 32'd1);
        chk("t5_busy",        32'(vif.busy),  32'd1);
        vif.change      = 1'b1;
        vif.drop_sensor = 1'b1;
        tick();
        vif.change      = 1'b0;
        vif.drop_sensor = 1'b0;
        mc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (vif.change_sol || vif.motor_on || vif.vend_done || !vif.fault) mc++;
        end
        chk("t5_fault_sticky", 32'(mc),        32'd0);
        chk("t5_stock",        32'(vif.stock), 32'd10);
        reset = 1'b1;
        #1;
        chk("t5_rst_fault", 32'(vif.fault), 32'd0);
        chk("t5_rst_stock", 32'(vif.stock), 32'd10);
        tick();
        reset = 1'b0;
        tick();

        // 6: asynchronous reset in motor cycle 4 with a change queued
        vif.dispense = 1'b1;
        tick();
        vif.dispense = 1'b0;
        tick();
        vif.change = 1'b1;
        tick();
        vif.change = 1'b0;
        tick();
        tick();
        chk("t6_motor_c4", 32'(vif.motor_on), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_motor", 32'(vif.motor_on), 32'd0);
        chk("t6_async_busy",  32'(vif.busy),     32'd0);
        tick();
        reset = 1'b0;
        mc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (vif.motor_on || vif.change_sol || vif.busy) mc++;
        end
        chk("t6_idle_after", 32'(mc),        32'd0);
        chk("t6_stock",      32'(vif.stock), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
